// File: rtl/frame_scheduler.sv
// Frame sequencer feeding the word repeater: P preamble words, L upstream payload words, G idle cycles.
// Registered single-stage AXI-style output; s_tready is the only combinational output.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for enable && s_tvalid; shadows latch on exit
// PREAMBLE | loading the shadow preamble word, pre-count times
// PAYLOAD  | passing upstream words; last one carries m_tlast
// GAP      | drain the last word, then hold m_tvalid low for G cycles
module frame_scheduler #(
    parameter int          PRE_W        = 4,
    parameter int          LEN_W        = 12,
    parameter int          GAP_W        = 8,
    parameter logic [31:0] DEF_PREAMBLE = 32'hCCCC_CCCC,
    parameter int          DEF_PRE      = 2,
    parameter int          DEF_LEN      = 64,
    parameter int          DEF_GAP      = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        cfg_wr,
    input  logic [1:0]  cfg_addr,
    input  logic [31:0] cfg_wdata,
    input  logic [31:0] s_tdata,
    input  logic        s_tvalid,
    output logic        s_tready,
    output logic [31:0] m_tdata,
    output logic        m_tvalid,
    input  logic        m_tready,
    output logic        m_tlast,
    output logic        busy,
    output logic [15:0] frame_cnt
);

    localparam int CNT_W = (LEN_W > PRE_W) ? ((LEN_W > GAP_W) ? LEN_W : GAP_W)
                                           : ((PRE_W > GAP_W) ? PRE_W : GAP_W);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic [1:0] {IDLE, PREAMBLE, PAYLOAD, GAP} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        cfg_word_q, cfg_word_d;
    logic [PRE_W-1:0]   cfg_pre_q, cfg_pre_d;
    logic [LEN_W-1:0]   cfg_len_q, cfg_len_d;
    logic [GAP_W-1:0]   cfg_gap_q, cfg_gap_d;
    logic [31:0]        sh_word_q, sh_word_d;
    logic [CNT_W-1:0]   sh_len_m1_q, sh_len_m1_d;
    logic [GAP_W-1:0]   sh_gap_q, sh_gap_d;
    logic [31:0]        m_tdata_q, m_tdata_d;
    logic               m_tvalid_q, m_tvalid_d;
    logic               m_tlast_q, m_tlast_d;
    logic               busy_q, busy_d;
    logic [15:0]        frame_cnt_q, frame_cnt_d;
    logic               ld_ok;
    logic [CNT_W-1:0]   cfg_len_m1;

    assign ld_ok     = !m_tvalid_q || m_tready;
    assign s_tready  = (state_q == PAYLOAD) && ld_ok;
    assign m_tdata   = m_tdata_q;
    assign m_tvalid  = m_tvalid_q;
    assign m_tlast   = m_tlast_q;
    assign busy      = busy_q;
    assign frame_cnt = frame_cnt_q;

    // A programmed length of 0 behaves as a single-word payload.
    assign cfg_len_m1 = (cfg_len_q == '0) ? '0 : CNT_W'(cfg_len_q) - CNT_ONE;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cfg_word_d  = cfg_word_q;
        cfg_pre_d   = cfg_pre_q;
        cfg_len_d   = cfg_len_q;
        cfg_gap_d   = cfg_gap_q;
        sh_word_d   = sh_word_q;
        sh_len_m1_d = sh_len_m1_q;
        sh_gap_d    = sh_gap_q;
        m_tdata_d   = m_tdata_q;
        m_tvalid_d  = m_tvalid_q;
        m_tlast_d   = m_tlast_q;
        frame_cnt_d = frame_cnt_q;

        if (m_tvalid_q && m_tready) begin
            m_tvalid_d = 1'b0;
            if (m_tlast_q) frame_cnt_d = frame_cnt_q + 16'd1;
        end

        if (cfg_wr) begin
            case (cfg_addr)
                2'd0:    cfg_word_d = cfg_wdata;
                2'd1:    cfg_pre_d  = cfg_wdata[PRE_W-1:0];
                2'd2:    cfg_len_d  = cfg_wdata[LEN_W-1:0];
                default: cfg_gap_d  = cfg_wdata[GAP_W-1:0];
            endcase
        end

        case (state_q)
            IDLE: begin
                if (enable && s_tvalid) begin
                    // Shadows take the pre-write register values if cfg_wr coincides.
                    sh_word_d   = cfg_word_q;
                    sh_len_m1_d = cfg_len_m1;
                    sh_gap_d    = cfg_gap_q;
                    if (cfg_pre_q != '0) begin
                        state_d = PREAMBLE;
                        cnt_d   = CNT_W'(cfg_pre_q) - CNT_ONE;
                    end else begin
                        state_d = PAYLOAD;
                        cnt_d   = cfg_len_m1;
                    end
                end
            end
            PREAMBLE: begin
                if (ld_ok) begin
                    m_tdata_d  = sh_word_q;
                    m_tlast_d  = 1'b0;
                    m_tvalid_d = 1'b1;
                    if (cnt_q == '0) begin
                        state_d = PAYLOAD;
                        cnt_d   = sh_len_m1_q;
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
            end
            PAYLOAD: begin
                if (s_tvalid && ld_ok) begin
                    m_tdata_d  = s_tdata;
                    m_tlast_d  = (cnt_q == '0);
                    m_tvalid_d = 1'b1;
                    if (cnt_q == '0) begin
                        if (sh_gap_q != '0) begin
                            state_d = GAP;
                            cnt_d   = CNT_W'(sh_gap_q) - CNT_ONE;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        cnt_d = cnt_q - CNT_ONE;
                    end
                end
            end
            GAP: begin
                // Gap cycles only count once the final word has left the output stage.
                if (!m_tvalid_q) begin
                    if (cnt_q == '0) state_d = IDLE;
                    else             cnt_d   = cnt_q - CNT_ONE;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE) || m_tvalid_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            cfg_word_q  <= DEF_PREAMBLE;
            cfg_pre_q   <= PRE_W'(DEF_PRE);
            cfg_len_q   <= LEN_W'(DEF_LEN);
            cfg_gap_q   <= GAP_W'(DEF_GAP);
            sh_word_q   <= DEF_PREAMBLE;
            sh_len_m1_q <= '0;
            sh_gap_q    <= '0;
            m_tdata_q   <= '0;
            m_tvalid_q  <= 1'b0;
            m_tlast_q   <= 1'b0;
            busy_q      <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cfg_word_q  <= cfg_word_d;
            cfg_pre_q   <= cfg_pre_d;
            cfg_len_q   <= cfg_len_d;
            cfg_gap_q   <= cfg_gap_d;
            sh_word_q   <= sh_word_d;
            sh_len_m1_q <= sh_len_m1_d;
            sh_gap_q    <= sh_gap_d;
            m_tdata_q   <= m_tdata_d;
            m_tvalid_q  <= m_tvalid_d;
            m_tlast_q   <= m_tlast_d;
            busy_q      <= busy_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

endmodule
